bcd_updown_counter_scan: RTL and testbench

Parametrised multi-digit BCD up/down counter with programmable wrap limit, synchronous clear/load, internal tick prescaler and multiplexed 7-segment scan output. It is the generalised successor of the single-digit mod-U counter plus BCD decoder chain in the TinyTapeout top level: N digits, runtime modulus, terminal-count pulse, and time-multiplexed display drive.

---
 rtl/bcd_updown_counter_scan.sv | 162 ++++++++++++++++
 tb/tb_bcd_updown_counter_scan.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter_scan.sv
// Multi-digit BCD up/down counter with runtime wrap limit, prescaled stepping,
// terminal-count pulse and a time-multiplexed 7-segment scan output.
module bcd_updown_counter_scan #(
  parameter int DIGITS   = 2,
  parameter int DIV      = 4,
  parameter int SCAN_DIV = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  syn_clr,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [4*DIGITS-1:0]   max_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [6:0]    SEG_ZERO   = 7'b0111111;

  logic [PW-1:0]     presc_q, presc_d;
  logic [SW-1:0]     scan_q, scan_d;
  logic [W-1:0]      count_q, count_d;
  logic              tc_q, tc_d;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic [6:0]        seg_q, seg_d;
  logic              tick;
  logic              scan_adv;
  logic [3:0]        nib;

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int k = 0; k < DIGITS; k++)
      if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
    return r;
  endfunction

  // Ripple the carry upward: a 9 rolls to 0 and keeps carrying.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (v[4*k +: 4] >= 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (borrow) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;

    count_d = count_q;
    tc_d    = 1'b0;
    if (syn_clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = bcd_clamp(data_in);
    end else if (en && tick) begin
      // Packed BCD compares numerically as a plain unsigned vector.
      if (up) begin
        if (count_q >= max_val) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = bcd_inc(count_q);
        end
      end else begin
        if (count_q == '0) begin
          count_d = bcd_clamp(max_val);
          tc_d    = 1'b1;
        end else begin
          count_d = bcd_dec(count_q);
        end
      end
    end

    scan_adv = (scan_q == SCAN_LAST);
    scan_d   = scan_adv ? '0 : scan_q + 1'b1;
    dig_d    = scan_adv ? ((dig_q << 1) | (dig_q >> (DIGITS - 1))) : dig_q;

    nib = count_q[3:0];
    for (int k = 0; k < DIGITS; k++)
      if (dig_q[k]) nib = count_q[4*k +: 4];
    seg_d = seg_decode(nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      scan_q  <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
      dig_q   <= DIGITS'(1);
      seg_q   <= SEG_ZERO;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign seg     = seg_q;
  assign dig_sel = dig_q;

endmodule

// File: tb/tb_bcd_updown_counter_scan.sv
// Bench for bcd_updown_counter_scan: two instances (DIV=1 and DIV=4) share stimulus
// and are checked against an integer-valued reference model of the counter and scan.
module tb_bcd_updown_counter_scan;
  localparam int NI   = 2;
  localparam int SCAN = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, syn_clr, up, load;
  logic [7:0] data_in, max_val;
  logic [7:0] cnt_o  [NI];
  logic       tc_o   [NI];
  logic [6:0] seg_o  [NI];
  logic [1:0] dsel_o [NI];

  bcd_updown_counter_scan #(.DIGITS(2), .DIV(1), .SCAN_DIV(SCAN)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .syn_clr(syn_clr), .up(up), .load(load),
    .data_in(data_in), .max_val(max_val),
    .count(cnt_o[0]), .tc(tc_o[0]), .seg(seg_o[0]), .dig_sel(dsel_o[0])
  );

  bcd_updown_counter_scan #(.DIGITS(2), .DIV(4), .SCAN_DIV(SCAN)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .syn_clr(syn_clr), .up(up), .load(load),
    .data_in(data_in), .max_val(max_val),
    .count(cnt_o[1]), .tc(tc_o[1]), .seg(seg_o[1]), .dig_sel(dsel_o[1])
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: count kept as a plain decimal integer 0..99.
  int         div_of [NI] = '{1, 4};
  int         m_cnt  [NI];
  logic       m_tc   [NI];
  logic [6:0] m_seg  [NI];
  int         m_cyc;
  int         m_dig;
  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int clampv(input logic [7:0] x);
    int h, l;
    h = int'(x[7:4]);
    l = int'(x[3:0]);
    if (h > 9) h = 9;
    if (l > 9) l = 9;
    return h * 10 + l;
  endfunction

  function automatic int digit_of(input int v, input int k);
    return (k == 0) ? (v % 10) : (v / 10);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      int   old;
      logic tick;
      old      = m_cnt[i];
      m_seg[i] = seg_tbl[digit_of(old, m_dig)];
      tick     = ((m_cyc % div_of[i]) == div_of[i] - 1);
      m_tc[i]  = 1'b0;
      if (syn_clr) m_cnt[i] = 0;
      else if (load) m_cnt[i] = clampv(data_in);
      else if (en && tick) begin
        if (up) begin
          if (to_bcd(old) >= max_val) begin m_cnt[i] = 0; m_tc[i] = 1'b1; end
          else m_cnt[i] = old + 1;
        end else begin
          if (old == 0) begin m_cnt[i] = clampv(max_val); m_tc[i] = 1'b1; end
          else m_cnt[i] = old - 1;
        end
      end
    end
    m_cyc = m_cyc + 1;
    m_dig = (m_cyc / SCAN) % 2;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b0; syn_clr = 1'b0; up = 1'b1; load = 1'b0;
    data_in = 8'h00; max_val = 8'h59;
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_tc[i] = 1'b0; m_seg[i] = 7'h3F;
    end
    m_cyc = 0;
    m_dig = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < NI; i++) begin
      n_vec++; if (cnt_o[i] !== 8'h00) begin n_err++; $display("FAIL reset_count inst%0d: got %h want 00", i, cnt_o[i]); end
      n_vec++; if (tc_o[i] !== 1'b0) begin n_err++; $display("FAIL reset_tc inst%0d: got %b want 0", i, tc_o[i]); end
      n_vec++; if (dsel_o[i] !== 2'b01) begin n_err++; $display("FAIL reset_dig_sel inst%0d: got %b want 01", i, dsel_o[i]); end
      n_vec++; if (seg_o[i] !== 7'b0111111) begin n_err++; $display("FAIL reset_seg inst%0d: got %b want 0111111", i, seg_o[i]); end
    end
  endtask

  task automatic test_count_up();
    logic [7:0] exp_q[$];
    apply_reset();
    max_val = 8'h59; up = 1'b1; en = 1'b1;
    for (int v = 1; v <= 60; v++) exp_q.push_back(to_bcd(v % 60));
    for (int s = 1; s <= 60; s++) begin
      logic [7:0] e;
      cycle();
      e = exp_q.pop_front();
      n_vec++; if (cnt_o[0] !== e) begin n_err++; $display("FAIL up_count step%0d: got %h want %h", s, cnt_o[0], e); end
      n_vec++; if (tc_o[0] !== 1'(s == 60)) begin n_err++; $display("FAIL up_tc step%0d: got %b want %b", s, tc_o[0], s == 60); end
    end
  endtask

  task automatic test_count_down();
    logic [7:0] exp_q[$];
    logic       tc_q[$];
    int         v;
    apply_reset();
    max_val = 8'h59; up = 1'b0; en = 1'b1;
    v = 0;
    for (int s = 1; s <= 62; s++) begin
      tc_q.push_back(1'(v == 0));
      v = (v == 0) ? 59 : v - 1;
      exp_q.push_back(to_bcd(v));
    end
    for (int s = 1; s <= 62; s++) begin
      logic [7:0] e;
      logic       et;
      cycle();
      e  = exp_q.pop_front();
      et = tc_q.pop_front();
      n_vec++; if (cnt_o[0] !== e) begin n_err++; $display("FAIL down_count step%0d: got %h want %h", s, cnt_o[0], e); end
      n_vec++; if (tc_o[0] !== et) begin n_err++; $display("FAIL down_tc step%0d: got %b want %b", s, tc_o[0], et); end
      n_vec++; if (cnt_o[1] !== to_bcd(m_cnt[1])) begin n_err++; $display("FAIL down_div4_count cyc%0d: got %h want %h", s, cnt_o[1], to_bcd(m_cnt[1])); end
    end
  endtask

  task automatic test_load_clear();
    data_in = 8'h3F; load = 1'b1; en = 1'b1; syn_clr = 1'b0;
    cycle();
    for (int i = 0; i < NI; i++) begin
      n_vec++; if (cnt_o[i] !== 8'h39) begin n_err++; $display("FAIL load_clamp inst%0d: got %h want 39", i, cnt_o[i]); end
      n_vec++; if (tc_o[i] !== 1'b0) begin n_err++; $display("FAIL load_tc inst%0d: got %b want 0", i, tc_o[i]); end
    end
    syn_clr = 1'b1;
    cycle();
    for (int i = 0; i < NI; i++) begin
      n_vec++; if (cnt_o[i] !== 8'h00) begin n_err++; $display("FAIL clr_over_load inst%0d: got %h want 00", i, cnt_o[i]); end
    end
    syn_clr = 1'b0; load = 1'b0;
  endtask

  task automatic test_prescale();
    apply_reset();
    max_val = 8'h59; up = 1'b1; en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      en = (k == 7 || k == 8) ? 1'b0 : 1'b1;
      cycle();
      n_vec++; if (cnt_o[1] !== to_bcd(m_cnt[1])) begin n_err++; $display("FAIL div4_count edge%0d: got %h want %h", k, cnt_o[1], to_bcd(m_cnt[1])); end
      n_vec++; if (tc_o[1] !== m_tc[1]) begin n_err++; $display("FAIL div4_tc edge%0d: got %b want %b", k, tc_o[1], m_tc[1]); end
      if (k == 3) begin
        n_vec++; if (cnt_o[1] !== 8'h00) begin n_err++; $display("FAIL div4_first_early: got %h want 00", cnt_o[1]); end
      end
      if (k == 4) begin
        n_vec++; if (cnt_o[1] !== 8'h01) begin n_err++; $display("FAIL div4_first_step: got %h want 01", cnt_o[1]); end
      end
      if (k == 11) begin
        n_vec++; if (cnt_o[1] !== 8'h01) begin n_err++; $display("FAIL div4_en_gap: got %h want 01", cnt_o[1]); end
      end
      if (k == 16) begin
        n_vec++; if (cnt_o[1] !== 8'h03) begin n_err++; $display("FAIL div4_realigned: got %h want 03", cnt_o[1]); end
      end
    end
  endtask

  task automatic test_overrange();
    apply_reset();
    max_val = 8'h20; data_in = 8'h75; load = 1'b1;
    cycle();
    load = 1'b0;
    n_vec++; if (cnt_o[0] !== 8'h75) begin n_err++; $display("FAIL over_load: got %h want 75", cnt_o[0]); end
    en = 1'b1; up = 1'b1;
    cycle();
    n_vec++; if (cnt_o[0] !== 8'h00) begin n_err++; $display("FAIL over_wrap: got %h want 00", cnt_o[0]); end
    n_vec++; if (tc_o[0] !== 1'b1) begin n_err++; $display("FAIL over_wrap_tc: got %b want 1", tc_o[0]); end
    max_val = 8'h00;
    for (int k = 0; k < 4; k++) begin
      up = k[0];
      cycle();
      n_vec++; if (cnt_o[0] !== 8'h00) begin n_err++; $display("FAIL max0_count step%0d: got %h want 00", k, cnt_o[0]); end
      n_vec++; if (tc_o[0] !== 1'b1) begin n_err++; $display("FAIL max0_tc step%0d: got %b want 1", k, tc_o[0]); end
    end
  endtask

  task automatic test_scan();
    apply_reset();
    en = 1'b0; data_in = 8'h42; load = 1'b1;
    cycle();
    load = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      logic [1:0] ed;
      cycle();
      ed = 2'b01 << m_dig;
      n_vec++; if (dsel_o[0] !== ed) begin n_err++; $display("FAIL scan_dig_sel edge%0d: got %b want %b", k, dsel_o[0], ed); end
      n_vec++; if (seg_o[0] !== m_seg[0]) begin n_err++; $display("FAIL scan_seg edge%0d: got %b want %b", k, seg_o[0], m_seg[0]); end
      if (k == 5) begin
        n_vec++; if (seg_o[0] !== 7'b1011011) begin n_err++; $display("FAIL scan_seg_lsd: got %b want 1011011", seg_o[0]); end
      end
      if (k == 12) begin
        n_vec++; if (seg_o[0] !== 7'b1100110) begin n_err++; $display("FAIL scan_seg_msd: got %b want 1100110", seg_o[0]); end
        n_vec++; if (dsel_o[0] !== 2'b10) begin n_err++; $display("FAIL scan_dig_msd: got %b want 10", dsel_o[0]); end
      end
    end
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < NI; i++) begin
      n_vec++; if (dsel_o[i] !== 2'b01) begin n_err++; $display("FAIL async_rst_dig inst%0d: got %b want 01", i, dsel_o[i]); end
      n_vec++; if (seg_o[i] !== 7'b0111111) begin n_err++; $display("FAIL async_rst_seg inst%0d: got %b want 0111111", i, seg_o[i]); end
      n_vec++; if (cnt_o[i] !== 8'h00) begin n_err++; $display("FAIL async_rst_count inst%0d: got %h want 00", i, cnt_o[i]); end
    end
    apply_reset();
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      syn_clr = ($urandom_range(0, 24) == 0);
      load    = ($urandom_range(0, 14) == 0);
      en      = ($urandom_range(0, 3) != 0);
      up      = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      if ($urandom_range(0, 29) == 0) max_val = to_bcd($urandom_range(0, 99));
      else if ($urandom_range(0, 99) == 0) max_val = 8'h00;
      cycle();
      for (int i = 0; i < NI; i++) begin
        logic [1:0] ed;
        ed = 2'b01 << m_dig;
        n_vec++; if (cnt_o[i] !== to_bcd(m_cnt[i])) begin n_err++; $display("FAIL rand_count inst%0d cyc%0d: got %h want %h", i, k, cnt_o[i], to_bcd(m_cnt[i])); end
        n_vec++; if (tc_o[i] !== m_tc[i]) begin n_err++; $display("FAIL rand_tc inst%0d cyc%0d: got %b want %b", i, k, tc_o[i], m_tc[i]); end
        n_vec++; if (seg_o[i] !== m_seg[i]) begin n_err++; $display("FAIL rand_seg inst%0d cyc%0d: got %b want %b", i, k, seg_o[i], m_seg[i]); end
        n_vec++; if (dsel_o[i] !== ed) begin n_err++; $display("FAIL rand_dig_sel inst%0d cyc%0d: got %b want %b", i, k, dsel_o[i], ed); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clear();
    test_prescale();
    test_overrange();
    test_scan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
